// File: rtl/symbol_sync.sv
// Symbol timing recovery and decimation: sign-simplified Gardner detector with
// an error accumulator that stretches or shortens one symbol period by a sample.
module symbol_sync #(
   parameter int SamplesPerSymbol = 4,
   parameter int Threshold        = 4096,
   parameter int AccWidth         = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [11:0] in,
   input  logic               in_valid,
   output logic signed [11:0] sym_out,
   output logic               sym_valid,
   output logic               slip_early,
   output logic               slip_late
);

   localparam int P  = SamplesPerSymbol;
   localparam int CW = $clog2(P + 2);
   localparam int W  = AccWidth + 2;
   localparam logic signed [W-1:0] SAT = W'((1 <<< (AccWidth - 1)) - 1);
   localparam logic signed [W-1:0] THR = W'(Threshold);

   generate
      if ((P < 4) || ((P % 2) != 0)) begin : g_bad_param
         $error("symbol_sync: SamplesPerSymbol must be even and >= 4");
      end
   endgenerate

   logic signed [11:0]         hist_q [P];
   logic signed [11:0]         hist_d [P];
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [CW-1:0]              per_q, per_d;
   logic signed [AccWidth-1:0] acc_q, acc_d;
   logic signed [11:0]         sym_out_q, sym_out_d;
   logic                       sym_valid_q, sym_valid_d;
   logic                       slip_early_q, slip_early_d;
   logic                       slip_late_q, slip_late_d;

   logic signed [11:0]         mid, prev;
   logic signed [12:0]         diff, err;
   logic signed [W-1:0]        sum, acc_n;

   always_comb begin
      hist_d       = hist_q;
      cnt_d        = cnt_q;
      per_d        = per_q;
      acc_d        = acc_q;
      sym_out_d    = sym_out_q;
      sym_valid_d  = 1'b0;
      slip_early_d = 1'b0;
      slip_late_d  = 1'b0;

      // history is read before this cycle's shift: h[k-1] is k samples older
      mid  = hist_q[P/2 - 1];
      prev = hist_q[P - 1];
      diff = {prev[11], prev} - {in[11], in};
      if (mid == '0)
         err = '0;
      else if (mid[11])
         err = -diff;
      else
         err = diff;

      sum = $signed({{(W - AccWidth){acc_q[AccWidth-1]}}, acc_q})
          + $signed({{(W - 13){err[12]}}, err});
      acc_n = sum;
      if (sum > SAT)
         acc_n = SAT;
      else if (sum < -SAT)
         acc_n = -SAT;

      if (in_valid) begin
         hist_d[0] = in;
         for (int i = 1; i < P; i++) begin
            hist_d[i] = hist_q[i-1];
         end
         if (cnt_q == per_q - CW'(1)) begin
            cnt_d       = '0;
            sym_out_d   = in;
            sym_valid_d = 1'b1;
            if (acc_n >= THR) begin
               slip_early_d = 1'b1;
               per_d        = CW'(P + 1);
               acc_d        = '0;
            end else if (acc_n <= -THR) begin
               slip_late_d = 1'b1;
               per_d       = CW'(P - 1);
               acc_d       = '0;
            end else begin
               per_d = CW'(P);
               acc_d = acc_n[AccWidth-1:0];
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < P; i++) begin
            hist_q[i] <= '0;
         end
         cnt_q        <= '0;
         per_q        <= CW'(P);
         acc_q        <= '0;
         sym_out_q    <= '0;
         sym_valid_q  <= 1'b0;
         slip_early_q <= 1'b0;
         slip_late_q  <= 1'b0;
      end else begin
         hist_q       <= hist_d;
         cnt_q        <= cnt_d;
         per_q        <= per_d;
         acc_q        <= acc_d;
         sym_out_q    <= sym_out_d;
         sym_valid_q  <= sym_valid_d;
         slip_early_q <= slip_early_d;
         slip_late_q  <= slip_late_d;
      end
   end

   assign sym_out    = sym_out_q;
   assign sym_valid  = sym_valid_q;
   assign slip_early = slip_early_q;
   assign slip_late  = slip_late_q;

endmodule

// File: tb/tb_symbol_sync.sv
// Bench for symbol_sync: three instances (normal, unreachable and saturation-edge
// thresholds) share one stimulus stream and are scored against a sample-list model.
module tb_symbol_sync;

   localparam int P   = 4;
   localparam int SAT = 131071;
   int thr [3] = '{4096, 131072, 131071};

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [11:0] in_s = '0;
   logic signed [11:0] so [3];
   logic               sv [3];
   logic               se [3];
   logic               sl [3];

   symbol_sync #(.SamplesPerSymbol(4), .Threshold(4096), .AccWidth(18)) u_dut0 (
      .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid),
      .sym_out(so[0]), .sym_valid(sv[0]), .slip_early(se[0]), .slip_late(sl[0]));
   symbol_sync #(.SamplesPerSymbol(4), .Threshold(131072), .AccWidth(18)) u_dut1 (
      .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid),
      .sym_out(so[1]), .sym_valid(sv[1]), .slip_early(se[1]), .slip_late(sl[1]));
   symbol_sync #(.SamplesPerSymbol(4), .Threshold(131071), .AccWidth(18)) u_dut2 (
      .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid),
      .sym_out(so[2]), .sym_valid(sv[2]), .slip_early(se[2]), .slip_late(sl[2]));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int inst;
      int cyc;
      bit vld;
      int sym;
      bit early;
      bit late;
   } item_t;

   item_t  sbq [$];
   int     checks = 0;
   int     errors = 0;
   bit     mon_en = 1'b0;
   int     last_sym [3] = '{0, 0, 0};

   // reference model: list of valid samples since reset plus per-instance timing state
   int     hist_m [$];
   int     cnt_m [3] = '{0, 0, 0};
   int     per_m [3] = '{P, P, P};
   longint acc_m [3] = '{0, 0, 0};
   int     tog = 1;

   function automatic int sgn(int v);
      return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
   endfunction

   function automatic int older(int k);
      int idx;
      idx = hist_m.size() - k;
      return (idx >= 0) ? hist_m[idx] : 0;
   endfunction

   task automatic drive(bit r, bit v, int x);
      item_t  it;
      longint a;
      int     e;
      rst      = r;
      in_valid = v;
      in_s     = 12'(x);
      if (r) begin
         hist_m.delete();
         for (int i = 0; i < 3; i++) begin
            cnt_m[i] = 0; per_m[i] = P; acc_m[i] = 0;
            it.inst = i; it.cyc = cyc + 1; it.vld = 0; it.sym = 0; it.early = 0; it.late = 0;
            sbq.push_back(it);
         end
      end else if (v) begin
         for (int i = 0; i < 3; i++) begin
            if (cnt_m[i] + 1 == per_m[i]) begin
               e = sgn(older(P/2)) * (older(P) - x);
               a = acc_m[i] + e;
               if (a > SAT) a = SAT;
               if (a < -SAT) a = -SAT;
               it.inst = i; it.cyc = cyc + 1; it.vld = 1; it.sym = x; it.early = 0; it.late = 0;
               if (a >= thr[i]) begin
                  it.early = 1; per_m[i] = P + 1; acc_m[i] = 0;
               end else if (a <= -thr[i]) begin
                  it.late = 1; per_m[i] = P - 1; acc_m[i] = 0;
               end else begin
                  per_m[i] = P; acc_m[i] = a;
               end
               cnt_m[i] = 0;
               sbq.push_back(it);
            end else begin
               cnt_m[i]++;
            end
         end
         hist_m.push_back(x);
         if (hist_m.size() > 8) void'(hist_m.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   // Gardner-style zero-crossing stream: on-time samples alternate +/-amp, the
   // mid sample carries pol*sign(next on-time); pol=+1 gives e=-2*amp (late).
   task automatic stream(int lead, int amp, int pol, int n, bit gaps);
      int off;
      int x;
      bit v;
      for (int k = 0; k < n; k++) begin
         v = gaps ? ($urandom_range(3) != 0) : 1'b1;
         if (v) begin
            off = per_m[lead] - 1 - cnt_m[lead];
            x   = 0;
            if (off == 0) begin
               x   = tog * amp;
               tog = -tog;
            end else if (off == P/2) begin
               x = pol * 200 * tog;
            end
            drive(1'b0, 1'b1, x);
         end else begin
            drive(1'b0, 1'b0, int'($urandom_range(4095)) - 2048);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            int  idx;
            bit  ev, ee, el;
            int  es;
            idx = -1;
            for (int j = 0; j < sbq.size(); j++) begin
               if (sbq[j].inst == i) begin
                  idx = j;
                  break;
               end
            end
            ev = 0; ee = 0; el = 0; es = last_sym[i];
            if (idx >= 0 && sbq[idx].cyc <= cyc) begin
               if (sbq[idx].cyc < cyc) begin
                  errors++;
                  $display("FAIL stale_item inst%0d cyc %0d: item for cyc %0d never matched", i, cyc, sbq[idx].cyc);
               end else begin
                  ev = sbq[idx].vld; ee = sbq[idx].early; el = sbq[idx].late; es = sbq[idx].sym;
                  last_sym[i] = es;
               end
               sbq.delete(idx);
            end
            checks++;
            if (sv[i] !== ev || so[i] !== 12'(es) || se[i] !== ee || sl[i] !== el) begin
               errors++;
               $display("FAIL outputs inst%0d cyc %0d: got valid=%0b sym=%0d early=%0b late=%0b, expected valid=%0b sym=%0d early=%0b late=%0b",
                        i, cyc, sv[i], $signed(so[i]), se[i], sl[i], ev, es, ee, el);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // constant stream, every cycle, then with alternating gaps
      for (int k = 0; k < 40; k++) drive(1'b0, 1'b1, 100);
      for (int k = 0; k < 40; k++) drive(1'b0, k[0] == 1'b0, 100);

      // late stream -> slip_late, then early stream -> slip_early
      drive(1'b1, 1'b0, 0);
      stream(0, 1000, 1, 60, 1'b1);
      drive(1'b1, 1'b0, 0);
      stream(0, 1000, -1, 60, 1'b1);

      // mid-symbol reset with in_valid high in the same cycle
      drive(1'b1, 1'b0, 0);
      for (int k = 0; k < 20 && cnt_m[0] != 2; k++) stream(0, 1000, 1, 1, 1'b0);
      drive(1'b1, 1'b1, 500);
      stream(0, 1000, 1, 40, 1'b0);

      // saturation: e=-4000 per symbol, paced by the saturation-edge instance
      drive(1'b1, 1'b0, 0);
      stream(2, 2000, 1, 200, 1'b0);
      stream(1, 2000, -1, 40, 1'b1);

      // random samples, random valid, occasional reset
      for (int k = 0; k < 300; k++) begin
         drive($urandom_range(99) == 0, $urandom_range(1) == 1, int'($urandom_range(4095)) - 2048);
      end

      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 0);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected outputs never seen, required 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/symbol_sync.md
Name: symbol_sync

Overview:
- Symbol timing recovery and decimation stage, directly downstream of the 20-tap root-raised-cosine matched filter.
- Takes the filter's 12-bit output at 4 samples/symbol (2 MS/s in, 500 kS/s out).
- Estimates the timing error once per symbol with a sign-simplified Gardner detector and slips the decimation phase by one sample when the accumulated error crosses a threshold.
- Emits one 12-bit on-time sample per symbol, qualified by a strobe.

Parameters:
- SamplesPerSymbol, 4: nominal decimation period; must be even and >= 4 (elaboration $error otherwise).
- Threshold, 4096: accumulated-error magnitude that triggers a phase slip.
- AccWidth, 18: signed error-accumulator width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in  in  12  signed filtered sample (two's complement)
- in_valid  in  1  in is a new sample this cycle; may be held low for any number of cycles
- sym_out  out  12  signed on-time symbol sample
- sym_valid  out  1  one-cycle pulse, sym_out is new
- slip_early  out  1  one-cycle pulse: next symbol period is lengthened (P+1)
- slip_late  out  1  one-cycle pulse: next symbol period is shortened (P-1)

Behaviour:
- Reset (rst sampled high at a clk edge):
  - sym_out=0, sym_valid=0, slip_early=0, slip_late=0.
  - Sample history h[0..P-1]=0, phase counter=0, accumulator=0, current period=P.
  - Takes priority over in_valid in the same cycle. Mid-symbol reset discards the partial symbol; no strobe is emitted.
- Idle: when in_valid=0, all state holds and every pulse output is 0 the next cycle.
- On each in_valid=1:
  - Shift in into the history; h[0] is newest.
  - If counter == period-1 (terminal), this is a symbol instant; otherwise counter increments.
- Symbol instant, registered, so outputs appear 1 cycle after the in_valid edge:
  - Samples: cur = in, mid = sample P/2 samples older, prev = sample P samples older. These are taken from the history before the shift.
  - sym_out <= cur; sym_valid <= 1.
  - Error: e = sign(mid)*(prev - cur), 13-bit signed. sign(mid) is +1 if mid>0, -1 if mid<0, 0 if mid==0. This uses no multiplier.
  - Accumulator: acc_n = acc + sign-extended e, saturating at ±(2^(AccWidth-1)-1).
  - If acc_n >= Threshold: slip_early<=1, next period = P+1, acc<=0.
  - Else if acc_n <= -Threshold: slip_late<=1, next period = P-1, acc<=0.
  - Else: next period = P, acc<=acc_n.
  - Counter <= 0.
  - An adjusted period applies to exactly one symbol, then reverts to P.
- Interpretation: negative error means sampling late.
- History indexing always refers to actual past valid samples, whatever the current period length.
- Start-up: the first symbol is emitted at the P-th valid sample after reset, using the zero-filled history. No startup gating.
- Accumulator saturation is held (no wrap); the slip still fires on the saturated value.
- At most one of slip_early/slip_late is high in any cycle. Each coincides with sym_valid.

Test Plan:
1. Reset, then in=100 with in_valid every cycle for 40 cycles -> sym_valid on every 4th valid sample (first at valid #4, +1 cycle), sym_out=100. After the first symbol e=0, no slip pulses.
2. Gaps: same stream with in_valid toggling 1,0,1,0 -> strobes only after every 4th valid sample, at the same values. Outputs are 0/held during gaps.
3. Late-sampling stream: period-4 pattern with prev=-1000, mid=+200, cur=+1000 at each symbol instant -> e=-2000 per symbol; acc=-2000, then -4000, then -6000. slip_late pulses with the 3rd sym_valid; the next symbol arrives 3 valid samples later; the following one after 4; acc restarts at 0.
4. Mirror of 3 with e=+2000 (mid=-200) -> slip_early on the 3rd symbol; the next period is 5 valid samples.
5. Assert rst for 1 cycle while the counter is 2 -> all outputs 0 next cycle. No strobe until 4 fresh valid samples; the accumulator restarts from 0 (a stream as in 3 needs 3 new symbols to slip).
6. Saturation: Threshold set to 2^17 (unreachable) with e=-4000 repeatedly -> acc clamps at -131071, no wrap to positive, no slip pulses.
